// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffer pipeline register with registered in_ready, flush and
// a saturating stall counter. Occupancy is the FSM state itself.
module pipe_stage_reg #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cycles,
  input  logic             clear_stats
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t           st, st_nxt;
  logic [WIDTH-1:0] skid_data;
  logic             xfer_in, xfer_out;
  logic             load_main, load_skid, main_from_skid;

  // Encoding makes the handshake outputs plain decodes of the state flops.
  assign in_ready  = (st != FULL);
  assign out_valid = (st != EMPTY);
  assign occupancy = st;

  assign xfer_in  = in_valid & in_ready;
  assign xfer_out = out_valid & out_ready;

  always_comb begin
    st_nxt         = st;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (st)
      EMPTY: if (xfer_in) begin
        st_nxt    = ONE;
        load_main = 1'b1;
      end
      ONE: case ({xfer_in, xfer_out})
        2'b11:   load_main = 1'b1;
        2'b10: begin
          st_nxt    = FULL;
          load_skid = 1'b1;
        end
        2'b01:   st_nxt = EMPTY;
        default: ;
      endcase
      FULL: if (xfer_out) begin
        st_nxt         = ONE;
        main_from_skid = 1'b1;
      end
      default: st_nxt = EMPTY;
    endcase
    // Data loads on a flush edge are harmless: both valids drop.
    if (flush) st_nxt = EMPTY;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st        <= EMPTY;
      out_data  <= '0;
      skid_data <= '0;
    end else begin
      st <= st_nxt;
      if (load_main)           out_data <= in_data;
      else if (main_from_skid) out_data <= skid_data;
      if (load_skid)           skid_data <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stall_cycles <= '0;
    else if (clear_stats)
      stall_cycles <= '0;
    else if (out_valid && !out_ready && !(&stall_cycles))
      stall_cycles <= stall_cycles + CNT_W'(1);
  end

endmodule
